// File: rtl/i2s_capture_rx_if.sv
// i2s_capture_rx_if: pin and stream bundle for the I2S record-path receiver.
// Holds the three codec pins, the stereo frame stream, the overflow and
// framing status, and a debug view of the receiver FSM state.
//
// Stream handshake: a frame transfers on every mclk rising edge where
// frame_valid && frame_ready are both high. While frame_valid is high and
// frame_ready is low, frame_left/frame_right stay stable. frame_valid never
// depends on frame_ready.
//
// Modports:
//   slave  - the receiver. It listens to the codec pins and serves frames.
//   master - the codec pins plus the frame consumer, i.e. the environment
//            around the receiver.
// SAMPLE_BITS must match the receiver's SAMPLE_BITS.
interface i2s_capture_rx_if #(
  parameter int SAMPLE_BITS = 16
);
  logic                   audio_I2S_bclk;
  logic                   audio_I2S_reclrc;
  logic                   audio_I2S_recdat;
  logic [SAMPLE_BITS-1:0] frame_left;
  logic [SAMPLE_BITS-1:0] frame_right;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   overflow;
  logic                   clear_overflow;
  logic                   framing_error;
  logic [1:0]             dbg_state;

  modport slave (
    input  audio_I2S_bclk,
    input  audio_I2S_reclrc,
    input  audio_I2S_recdat,
    input  frame_ready,
    input  clear_overflow,
    output frame_left,
    output frame_right,
    output frame_valid,
    output overflow,
    output framing_error,
    output dbg_state
  );

  modport master (
    output audio_I2S_bclk,
    output audio_I2S_reclrc,
    output audio_I2S_recdat,
    output frame_ready,
    output clear_overflow,
    input  frame_left,
    input  frame_right,
    input  frame_valid,
    input  overflow,
    input  framing_error,
    input  dbg_state
  );
endinterface

// File: rtl/i2s_capture_rx.sv
// i2s_capture_rx: I2S record-path receiver.
// The block oversamples bclk, reclrc and recdat on mclk. It deserialises
// MSB-first words, pairs left and right words into stereo frames, and
// buffers those frames in a small FIFO that feeds a valid/ready stream.
//
// Optional build macro: I2S_RX_LEFT_JUSTIFIED_EN
//   undefined - standard I2S. The first bit after a word-select change is
//               the LSB of the previous word.
//   defined   - left-justified. The bit sampled at a word-select change is
//               the MSB of the new word.
//
// dbg_state encoding: 0 = IDLE, 1 = SHIFT, 2 = WAIT.
module i2s_capture_rx #(
  parameter int SAMPLE_BITS = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             mclk,
  input logic             rst,
  i2s_capture_rx_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(SAMPLE_BITS + 1);
  localparam int FW = 2 * SAMPLE_BITS;
  localparam logic [BW-1:0] WORD_LEN = BW'(SAMPLE_BITS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers and bit-event detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrc_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_bclk_prev;
  logic                   w_bclk;
  logic                   w_lrc;
  logic                   w_dat;
  logic                   w_bit_evt;

  // Move each asynchronous pin into the mclk domain through a flop chain.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bus.audio_I2S_bclk};
      r_lrc_sync  <= {r_lrc_sync[SYNC_STAGES-2:0],  bus.audio_I2S_reclrc};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0],  bus.audio_I2S_recdat};
      r_bclk_prev <= w_bclk;
    end
  end

  assign w_bclk    = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrc     = r_lrc_sync[SYNC_STAGES-1];
  assign w_dat     = r_dat_sync[SYNC_STAGES-1];
  // Sample on the rising edge of the synchronised bit clock.
  assign w_bit_evt = w_bclk & ~r_bclk_prev;

  // ---------------------------------------------------------------------
  // Deserialiser FSM
  // ---------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   r_channel;
  logic                   w_channel_nx;
  logic [BW-1:0]          r_bit_cnt;
  logic [BW-1:0]          w_cnt_nx;
  logic [BW-1:0]          w_cnt_inc;
  logic [SAMPLE_BITS-1:0] r_shreg;
  logic [SAMPLE_BITS-1:0] w_shreg_nx;
  logic [SAMPLE_BITS-1:0] w_shifted;
  logic                   r_lr_prev;
  logic                   w_lr_prev_nx;
  // The first bit event after reset has no earlier word-select sample to
  // compare against, so it cannot report an LR change.
  logic                   r_lr_valid;
  logic                   w_lr_valid_nx;
  logic                   w_lr_chg;
  logic [SAMPLE_BITS-1:0] r_left_hold;
  logic [SAMPLE_BITS-1:0] w_left_hold_nx;
  logic                   r_left_ok;
  logic                   w_left_ok_nx;
  logic                   r_ferr;
  logic                   w_ferr_nx;
  logic                   w_word_done;
  logic                   w_push;
  logic [FW-1:0]          w_push_data;
  logic [BW-1:0]          w_start_cnt;
  logic [SAMPLE_BITS-1:0] w_start_shreg;

  assign w_lr_chg    = r_lr_valid & (w_lrc != r_lr_prev);
  assign w_cnt_inc   = r_bit_cnt + BW'(1);
  assign w_shifted   = {r_shreg[SAMPLE_BITS-2:0], w_dat};
  assign w_push_data = {r_left_hold, w_shifted};

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  // Left-justified: the bit at the LR change is already the new MSB.
  assign w_start_cnt   = BW'(1);
  assign w_start_shreg = {{(SAMPLE_BITS-1){1'b0}}, w_dat};
`else
  // Standard I2S: the bit at the LR change belongs to the old word.
  assign w_start_cnt   = '0;
  assign w_start_shreg = r_shreg;
`endif

  // Register the FSM state, the word datapath and the error pulse.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_channel   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_lr_prev   <= 1'b0;
      r_lr_valid  <= 1'b0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_channel   <= w_channel_nx;
      r_bit_cnt   <= w_cnt_nx;
      r_shreg     <= w_shreg_nx;
      r_lr_prev   <= w_lr_prev_nx;
      r_lr_valid  <= w_lr_valid_nx;
      r_left_hold <= w_left_hold_nx;
      r_left_ok   <= w_left_ok_nx;
      r_ferr      <= w_ferr_nx;
    end
  end

  // Next-state logic. For each bit event: shift, then check for word
  // completion, then handle the LR change.
  always_comb begin
    w_state_nx     = r_state;
    w_channel_nx   = r_channel;
    w_cnt_nx       = r_bit_cnt;
    w_shreg_nx     = r_shreg;
    w_lr_prev_nx   = r_lr_prev;
    w_lr_valid_nx  = r_lr_valid;
    w_left_hold_nx = r_left_hold;
    w_left_ok_nx   = r_left_ok;
    w_ferr_nx      = 1'b0;
    w_word_done    = 1'b0;
    w_push         = 1'b0;

    if (w_bit_evt) begin
      w_lr_prev_nx  = w_lrc;
      w_lr_valid_nx = 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_lr_chg) begin
            w_channel_nx = w_lrc;
            w_cnt_nx     = w_start_cnt;
            w_shreg_nx   = w_start_shreg;
            w_state_nx   = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
          if (w_lr_chg) begin
            // The word was cut short, so drop it and start the new channel.
            w_ferr_nx    = 1'b1;
            w_channel_nx = w_lrc;
            w_cnt_nx     = w_start_cnt;
            w_shreg_nx   = w_start_shreg;
          end else begin
            w_shreg_nx = w_shifted;
            w_cnt_nx   = w_cnt_inc;
            if (w_cnt_inc == WORD_LEN) begin
              w_word_done = 1'b1;
              w_state_nx  = ST_WAIT;
            end
          end
`else
          w_shreg_nx = w_shifted;
          w_cnt_nx   = w_cnt_inc;
          if (w_cnt_inc == WORD_LEN) begin
            w_word_done = 1'b1;
            w_state_nx  = ST_WAIT;
          end else if (w_lr_chg) begin
            w_ferr_nx = 1'b1;
          end
          // The LSB arrives with the LR change, so the change is handled
          // after the completion check.
          if (w_lr_chg) begin
            w_channel_nx = w_lrc;
            w_cnt_nx     = w_start_cnt;
            w_shreg_nx   = w_start_shreg;
            w_state_nx   = ST_SHIFT;
          end
`endif
        end

        ST_WAIT: begin
          if (w_lr_chg) begin
            w_channel_nx = w_lrc;
            w_cnt_nx     = w_start_cnt;
            w_shreg_nx   = w_start_shreg;
            w_state_nx   = ST_SHIFT;
          end
        end

        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase

      // Pair words into frames. A left word waits in left_hold, and a right
      // word with no left partner is an error.
      if (w_word_done) begin
        if (!r_channel) begin
          w_left_hold_nx = w_shifted;
          w_left_ok_nx   = 1'b1;
        end else if (r_left_ok) begin
          w_push       = 1'b1;
          w_left_ok_nx = 1'b0;
        end else begin
          w_ferr_nx = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FIFO
  // ---------------------------------------------------------------------
  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = w_valid & bus.frame_ready;
  // When the FIFO is full, a pop in the same cycle frees a slot, so the
  // push still goes in.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Frame storage. The outputs are gated while the FIFO is empty, so the
  // storage needs no reset.
  always_ff @(posedge mclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two. The count
  // tells full apart from empty.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.frame_valid   = w_valid;
  assign bus.frame_left    = w_valid ? r_mem[r_rd_ptr][FW-1:SAMPLE_BITS] : '0;
  assign bus.frame_right   = w_valid ? r_mem[r_rd_ptr][SAMPLE_BITS-1:0]  : '0;
  assign bus.overflow      = r_overflow;
  assign bus.framing_error = r_ferr;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_i2s_capture_rx.sv
// tb_i2s_capture_rx: directed bench for i2s_capture_rx.
// The bench drives I2S frames with bclk = mclk/16 and 32 bclk per frame.
// Each expected frame is pushed into exp_q when its stimulus is issued. A
// monitor on the falling mclk edge pops and compares every transfer that
// the receiver presents.
module tb_i2s_capture_rx;
  localparam int SB    = 16;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int HALF  = 8;   // mclk cycles per bclk half period

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  i2s_capture_rx_if #(.SAMPLE_BITS(SB)) bus ();

  i2s_capture_rx #(
    .SAMPLE_BITS(SB),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [2*SB-1:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int ferr_cnt   = 0;
  int valid_cyc  = 0;
  int pop_cnt    = 0;
  logic prev_lsb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: compare every frame transfer against the head of exp_q.
  always @(negedge mclk) begin
    if (!rst) begin
      if (bus.framing_error) ferr_cnt++;
      if (bus.frame_valid) valid_cyc++;
      if (bus.frame_valid && bus.frame_ready) begin
        logic [2*SB-1:0] got;
        logic [2*SB-1:0] want;
        got = {bus.frame_left, bus.frame_right};
        pop_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got %h required no frame", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL frame_data: got %h required %h", got, want);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // One bclk period. Data and word select change while bclk is low. With
  // pulse set, frame_ready is raised for exactly the cycle in which the
  // receiver acts on this bit.
  task automatic send_bit(input logic lr, input logic d, input logic pulse);
    bus.audio_I2S_reclrc = lr;
    bus.audio_I2S_recdat = d;
    bus.audio_I2S_bclk   = 1'b0;
    tick(HALF);
    bus.audio_I2S_bclk = 1'b1;
    if (pulse) begin
      tick(SYNC);
      bus.frame_ready = 1'b1;
      tick(1);
      bus.frame_ready = 1'b0;
      tick(HALF - SYNC - 1);
    end else begin
      tick(HALF);
    end
  endtask

  task automatic preamble();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    prev_lsb = 1'b0;
  endtask

  task automatic send_frame_std(input logic [SB-1:0] l, input logic [SB-1:0] r);
    send_bit(1'b0, prev_lsb, 1'b0);
    for (int i = SB - 1; i >= 1; i--) send_bit(1'b0, l[i], 1'b0);
    send_bit(1'b1, l[0], 1'b0);
    for (int i = SB - 1; i >= 1; i--) send_bit(1'b1, r[i], 1'b0);
    prev_lsb = r[0];
  endtask

  task automatic send_frame_lj(input logic [SB-1:0] l, input logic [SB-1:0] r, input logic pulse);
    for (int i = SB - 1; i >= 0; i--) send_bit(1'b0, l[i], 1'b0);
    for (int i = SB - 1; i >= 0; i--) send_bit(1'b1, r[i], pulse && (i == 0));
  endtask

  // Frame in the format of the current build. In left-justified mode the
  // frame is pushed on its own last bit, so pulse applies to that bit.
  task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r, input logic pulse);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    send_frame_lj(l, r, pulse);
`else
    send_frame_std(l, r);
`endif
  endtask

  // In standard I2S, the trailing bit carries the last right LSB and
  // completes the pending frame.
  task automatic flush(input logic pulse);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    send_bit(1'b0, 1'b0, 1'b0);
`else
    send_bit(1'b0, prev_lsb, pulse);
`endif
    bus.audio_I2S_bclk = 1'b0;
    tick(12);
  endtask

  task automatic do_reset(input logic ready);
    rst                  = 1'b1;
    bus.audio_I2S_bclk   = 1'b0;
    bus.audio_I2S_reclrc = 1'b1;
    bus.audio_I2S_recdat = 1'b0;
    bus.frame_ready      = ready;
    bus.clear_overflow   = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);
  endtask

  // Bounded run time; an expired bound is reported as a failure.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int f0;
    int p0;
    int v0;
    logic [SB-1:0] ab;
    logic [SB-1:0] r2;

    // Reset state
    do_reset(1'b1);
    chk("rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_left", 32'(bus.frame_left), 32'd0);
    chk("rst_right", 32'(bus.frame_right), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_ferr", 32'(bus.framing_error), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);

    // 1: single frame
    f0 = ferr_cnt; v0 = valid_cyc; p0 = pop_cnt;
    preamble();
    exp_q.push_back({16'hA55A, 16'h1234});
    send_frame(16'hA55A, 16'h1234, 1'b0);
    flush(1'b0);
    chk("t1_valid_cycles", 32'(valid_cyc - v0), 32'd1);
    chk("t1_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 2: reset released at bit 6 of a right word
    rst                  = 1'b1;
    bus.audio_I2S_reclrc = 1'b1;
    tick(2);
    send_bit(1'b1, 1'b0, 1'b0);
    r2 = 16'h2222;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = SB - 1; i >= 1; i--) send_bit(1'b0, 1'(16'h1111 >> i), 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = SB - 1; i >= SB - 6; i--) send_bit(1'b1, r2[i], 1'b0);
    rst = 1'b0;
    f0 = ferr_cnt; p0 = pop_cnt;
    for (int i = SB - 7; i >= 1; i--) send_bit(1'b1, r2[i], 1'b0);
    prev_lsb = r2[0];
    exp_q.push_back({16'h8001, 16'h7FFE});
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    flush(1'b0);
    chk("t2_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: overflow with a stalled consumer, then drain and clear
    do_reset(1'b0);
    f0 = ferr_cnt; p0 = pop_cnt;
    preamble();
    for (int n = 0; n <= 8; n++) begin
      if (n < DEPTH) exp_q.push_back({SB'(n), ~SB'(n)});
      send_frame(SB'(n), ~SB'(n), 1'b0);
    end
    flush(1'b0);
    chk("t3_overflow_set", 32'(bus.overflow), 32'd1);
    chk("t3_valid_held", 32'(bus.frame_valid), 32'd1);
    chk("t3_head_left", 32'(bus.frame_left), 32'h0000);
    chk("t3_head_right", 32'(bus.frame_right), 32'hFFFF);
    bus.frame_ready = 1'b1;
    tick(20);
    chk("t3_pops", 32'(pop_cnt - p0), 32'd8);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    bus.clear_overflow = 1'b1;
    tick(1);
    bus.clear_overflow = 1'b0;
    chk("t3_overflow_clr", 32'(bus.overflow), 32'd0);
    chk("t3_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 4: word select toggles after 10 bits of a left word
    do_reset(1'b1);
    f0 = ferr_cnt; p0 = pop_cnt;
    preamble();
    ab = 16'hABCD;
    for (int i = SB - 1; i >= SB - 10; i--) send_bit(1'b0, ab[i], 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1, 1'b0);
    chk("t4_ferr_abort", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_no_push", 32'(pop_cnt - p0), 32'd0);
    // The orphaned right word that follows has no left partner.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0);
    prev_lsb = 1'b0;
    exp_q.push_back({16'h00FF, 16'hFF00});
    send_frame(16'h00FF, 16'hFF00, 1'b0);
    flush(1'b0);
    chk("t4_ferr_total", 32'(ferr_cnt - f0), 32'd2);
    chk("t4_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: push and pop in the same cycle while full
    do_reset(1'b0);
    p0 = pop_cnt;
    preamble();
    for (int n = 0; n < DEPTH; n++) begin
      exp_q.push_back({SB'(16'h0010 + n), SB'(16'hF000 + n)});
      send_frame(SB'(16'h0010 + n), SB'(16'hF000 + n), 1'b0);
    end
    exp_q.push_back({16'h5A5A, 16'hA5A5});
    send_frame(16'h5A5A, 16'hA5A5, 1'b1);
    flush(1'b1);
    chk("t5_no_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_one_pop", 32'(pop_cnt - p0), 32'd1);
    bus.frame_ready = 1'b1;
    tick(20);
    chk("t5_pops", 32'(pop_cnt - p0), 32'd9);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_no_overflow_end", 32'(bus.overflow), 32'd0);

    // 6: left-justified stimulus C3C3/3C3C
    do_reset(1'b1);
    p0 = pop_cnt;
    preamble();
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    exp_q.push_back({16'hC3C3, 16'h3C3C});
`else
    // Read with a one-bit delay, each word moves up one bit. The next word's
    // MSB or the trailing 0 fills the vacated LSB.
    exp_q.push_back({16'h8786, 16'h7878});
`endif
    send_frame_lj(16'hC3C3, 16'h3C3C, 1'b0);
    prev_lsb = 1'b0;
    flush(1'b0);
    chk("t6_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_capture_rx.md
Name: i2s_capture_rx

Overview:
I2S record-path receiver for the codec ADC output. Oversamples the bit clock, word-select and record data pins on `mclk` and deserialises MSB-first words. Assembles left/right pairs into stereo frames and buffers them in a small FIFO. Frames leave through a valid/ready stream toward sample storage and DSP logic.

Parameters:
SAMPLE_BITS, 16, bits per channel word, MSB first.
FIFO_DEPTH, 8, stereo frames buffered; power of two, >= 2.
SYNC_STAGES, 2, synchroniser flops on each pin input; >= 2.

Ports:
mclk  in  1  master clock (256x sample rate); the only clock.
rst  in  1  reset, synchronous, active-high.
audio_I2S_bclk  in  1  I2S bit clock, asynchronous to logic; bclk period >= 4 mclk.
audio_I2S_reclrc  in  1  record word select; 0 = left, 1 = right.
audio_I2S_recdat  in  1  record serial data.
frame_left  out  SAMPLE_BITS  left sample of FIFO head frame.
frame_right  out  SAMPLE_BITS  right sample of FIFO head frame.
frame_valid  out  1  FIFO non-empty.
frame_ready  in  1  consumer accepts head frame when high with frame_valid.
overflow  out  1  sticky; a completed frame was dropped.
clear_overflow  in  1  clears overflow.
framing_error  out  1  one-mclk pulse on a malformed word.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, partial words and left-hold flag discarded. Reset asserted mid-word or mid-frame drops all in-flight data.
- All three pins pass through SYNC_STAGES flops.
- Bit event: the synchronised bclk is 1 and its previous value was 0. That mclk cycle samples recdat and reclrc. Pin-to-event latency is SYNC_STAGES+1 mclk.
- LR change: the sampled reclrc differs from the value sampled at the previous bit event.
- Processing order within one bit event: shift first, check word completion, then handle the LR change.
- IDLE: ignore data until the first LR change. On that change, channel <= new reclrc, bit_cnt <= 0, go to SHIFT.
- SHIFT: each following bit event does shreg <= {shreg, recdat} and bit_cnt++.
- When bit_cnt reaches SAMPLE_BITS, the word is complete and the state goes to WAIT. The LSB is sampled at the same bit event that detects the next LR change (one-bit I2S delay).
- WAIT: extra bits ignored. An LR change re-enters SHIFT for the new channel.
- LR change in SHIFT with bit_cnt < SAMPLE_BITS: pulse framing_error, discard the word, restart SHIFT for the new channel.
- Completed left word: load left_hold and set left_ok.
- Completed right word with left_ok=1: push {left_hold, right} and clear left_ok.
- Completed right word with left_ok=0: discard and pulse framing_error.
- A second left word completing before a right word completes overwrites left_hold; no error.
- FIFO: a push becomes visible as frame_valid one mclk after the bit-event cycle. Pop occurs on frame_valid && frame_ready. The head frame is held stable while frame_valid && !frame_ready.
- Push while full with no pop: the frame is dropped and overflow is set. Push and pop in the same cycle while full: both succeed, no overflow.
- Frames are delivered in arrival order. Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- clear_overflow clears overflow on the next cycle. If a drop happens in the same cycle, set wins.

Optional Feature:
I2S_RX_LEFT_JUSTIFIED_EN
- Defined: left-justified format. At the bit event that detects an LR change, the sampled recdat is taken as bit 1 of the new word, after completion checks for the old word. Words complete after SAMPLE_BITS bits including that one.
- Undefined: standard I2S one-bit delay as described in Behaviour.

Test Plan:
1. Reset released, bclk = mclk/16, 32 bclk per frame, frame_ready=1, drive left=16'hA55A, right=16'h1234 -> exactly one frame_valid cycle with frame_left=A55A, frame_right=1234; framing_error stays 0.
2. rst deasserted mid-word (bit 6 of a right word) -> no frame for that partial pair; next pair 8001/7FFE captured correctly.
3. frame_ready=0, send 9 frames with left=n, right=~n for n=0..8 -> overflow=1 after the 9th. Then frame_ready=1 drains n=0..7 in order. clear_overflow -> overflow=0.
4. reclrc toggles after 10 bits of a left word -> one framing_error pulse, no push; the following full frame 00FF/FF00 is captured.
5. FIFO full, frame_ready=1 in the same cycle a new frame completes -> no overflow, count stays 8, new frame appears last in order.
6. With I2S_RX_LEFT_JUSTIFIED_EN, drive left-justified C3C3/3C3C -> captured exactly. The same stimulus without the macro -> values shifted by one bit.
